// File: rtl/disp_scan_ctrl.sv
// Refresh scheduler for a 4-digit multiplexed 7-segment display.
// Steps a one-hot digit select at a programmable dwell, latches the counter
// value once per frame (tear-free) and drives active-low anodes with optional
// leading-zero blanking.
module disp_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        blank_lz_i,
    input  logic [15:0] n_i,
    output logic [15:0] n_lat_o,
    output logic [3:0]  sel_o,
    output logic [3:0]  an_o,
    output logic        frame_tick_o
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    // Scan state is the one-hot digit select itself.
    typedef enum logic [3:0] {
        StDig0 = 4'b0001,
        StDig1 = 4'b0010,
        StDig2 = 4'b0100,
        StDig3 = 4'b1000
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     n_lat_q, n_lat_d;
    logic [3:0]      blank_q, blank_d;
    logic            frame_tick_q, frame_tick_d;

    // Blank leading zero digits from the top; digit 0 always stays lit.
    function automatic logic [3:0] lz_blank(input logic [15:0] n, input logic b);
        logic z3, z2, z1;
        z3 = (n[15:12] == 4'h0);
        z2 = z3 & (n[11:8] == 4'h0);
        z1 = z2 & (n[7:4] == 4'h0);
        return b ? {z3, z2, z1, 1'b0} : 4'b0000;
    endfunction

    // Next-state: prescaler, digit rotation and frame snapshot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_lat_d      = n_lat_q;
        blank_d      = blank_q;
        frame_tick_d = 1'b0;
        if (!en_i) begin
            // Track live data while frozen so re-enable shows current value.
            n_lat_d = n_i;
            blank_d = lz_blank(n_i, blank_lz_i);
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
            unique case (state_q)
                StDig0:  state_d = StDig1;
                StDig1:  state_d = StDig2;
                StDig2:  state_d = StDig3;
                StDig3:  state_d = StDig0;
                default: state_d = StDig0;
            endcase
            if (state_q == StDig3) begin
                n_lat_d      = n_i;
                blank_d      = lz_blank(n_i, blank_lz_i);
                frame_tick_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StDig0;
            cnt_q        <= '0;
            n_lat_q      <= 16'h0000;
            blank_q      <= 4'b0000;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_lat_q      <= n_lat_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Anodes are combinational so that en blanks the display in the same cycle.
    always_comb begin
        an_o = ~({4{en_i}} & sel_o & ~blank_q);
    end

    assign sel_o        = state_q;
    assign n_lat_o      = n_lat_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: PRESCALE=4 instance for the main
// scenarios plus a PRESCALE=1 instance sharing the same inputs.
module tb_disp_scan_ctrl;

    typedef struct packed {
        logic [3:0]  sel;
        logic [3:0]  an;
        logic        ft;
        logic [15:0] nlat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        blank_lz = 1'b0;
    logic [15:0] n = 16'h0000;

    logic [15:0] nlat0, nlat1;
    logic [3:0]  sel0, sel1, an0, an1;
    logic        ft0, ft1;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   oh_bad  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    disp_scan_ctrl #(.PRESCALE(4)) u_dut4 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .blank_lz_i   (blank_lz),
        .n_i          (n),
        .n_lat_o      (nlat0),
        .sel_o        (sel0),
        .an_o         (an0),
        .frame_tick_o (ft0)
    );

    disp_scan_ctrl #(.PRESCALE(1)) u_dut1 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .blank_lz_i   (blank_lz),
        .n_i          (n),
        .n_lat_o      (nlat1),
        .sel_o        (sel1),
        .an_o         (an1),
        .frame_tick_o (ft1)
    );

    // One-hot monitor over the whole run; tasks check the sticky count.
    always @(negedge clk) begin
        if (rst_n && (!$onehot(sel0) || !$onehot(sel1))) oh_bad <= oh_bad + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse released between edges; returns in "cycle 0".
    task automatic do_reset(input logic en_v, input logic bl_v, input logic [15:0] n_v);
        en = en_v;
        blank_lz = bl_v;
        n = n_v;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [3:0] onehot_of(input int k);
        logic [3:0] v;
        v = 4'b0001 << (k % 4);
        return v;
    endfunction

    task automatic test_reset();
        exp_t e, got, obs;
        do_reset(1'b1, 1'b0, 16'hABCD);
        e = '{sel: 4'b0001, an: 4'b1110, ft: 1'b0, nlat: 16'h0000};
        exp_q.push_back(e);
        got = exp_q.pop_front();
        obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
        n_tests++;
        if (obs !== got) begin
            n_fail++;
            $display("FAIL reset_state got %h exp %h", obs, got);
        end
        en = 1'b0;
        #1;
        n_tests++;
        if (an0 !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_an_en0 got %b exp 1111", an0);
        end
        en = 1'b1;
    endtask

    task automatic test_basic_scan();
        exp_t e, got, obs;
        do_reset(1'b1, 1'b0, 16'hABCD);
        for (int k = 0; k <= 20; k++) begin
            e.sel  = onehot_of(k / 4);
            e.an   = ~e.sel;
            e.ft   = (k == 16);
            e.nlat = (k >= 16) ? 16'hABCD : 16'h0000;
            exp_q.push_back(e);
            if (k > 0) step();
            got = exp_q.pop_front();
            obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL basic_scan k=%0d got sel=%b an=%b ft=%b nlat=%h exp sel=%b an=%b ft=%b nlat=%h",
                         k, obs.sel, obs.an, obs.ft, obs.nlat, got.sel, got.an, got.ft, got.nlat);
            end
        end
        n_tests++;
        if (oh_bad !== 0) begin
            n_fail++;
            $display("FAIL onehot_basic got %0d bad cycles exp 0", oh_bad);
        end
    endtask

    task automatic test_tear_free();
        exp_t e, got, obs;
        do_reset(1'b1, 1'b0, 16'h1234);
        repeat (16) step();
        for (int k = 17; k <= 33; k++) begin
            if (k == 18) n = 16'h5678;
            e.sel  = onehot_of(k / 4);
            e.an   = ~e.sel;
            e.ft   = (k == 32);
            e.nlat = (k >= 32) ? 16'h5678 : 16'h1234;
            exp_q.push_back(e);
            step();
            got = exp_q.pop_front();
            obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL tear_free k=%0d got %h exp %h", k, obs, got);
            end
        end
    endtask

    task automatic test_blanking();
        exp_t e, got, obs;
        logic [3:0] lit;
        do_reset(1'b1, 1'b1, 16'h0030);
        repeat (15) step();
        for (int k = 16; k <= 63; k++) begin
            if (k == 20) n = 16'h0000;
            if (k == 36) blank_lz = 1'b0;
            lit    = (k < 32) ? 4'b0011 : ((k < 48) ? 4'b0001 : 4'b1111);
            e.sel  = onehot_of(k / 4);
            e.an   = ~(e.sel & lit);
            e.ft   = (k == 16) || (k == 32) || (k == 48);
            e.nlat = (k < 32) ? 16'h0030 : 16'h0000;
            exp_q.push_back(e);
            step();
            got = exp_q.pop_front();
            obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL blanking k=%0d got sel=%b an=%b nlat=%h exp sel=%b an=%b nlat=%h",
                         k, obs.sel, obs.an, obs.nlat, got.sel, got.an, got.nlat);
            end
        end
    endtask

    task automatic test_en_toggle();
        exp_t e, got, obs;
        do_reset(1'b1, 1'b0, 16'hABCD);
        repeat (6) step();
        // Now sel=0010 with cnt=2.
        en = 1'b0;
        #1;
        n_tests++;
        if (an0 !== 4'b1111) begin
            n_fail++;
            $display("FAIL en0_an got %b exp 1111", an0);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                n = 16'h0005;
                blank_lz = 1'b1;
            end else begin
                n = 16'h1111 * 16'(i + 1);
            end
            e = '{sel: 4'b0010, an: 4'b1111, ft: 1'b0, nlat: n};
            exp_q.push_back(e);
            step();
            got = exp_q.pop_front();
            obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL en0_hold i=%0d got %h exp %h", i, obs, got);
            end
        end
        // Re-enable: data frozen, digit 1 blanked by the 0005 snapshot.
        en = 1'b1;
        blank_lz = 1'b0;
        n = 16'h9999;
        for (int i = 0; i < 5; i++) begin
            e = '{sel: (i == 0) ? 4'b0010 : 4'b0100, an: 4'b1111, ft: 1'b0, nlat: 16'h0005};
            exp_q.push_back(e);
            step();
            got = exp_q.pop_front();
            obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL en_resume i=%0d got %h exp %h", i, obs, got);
            end
        end
        // cnt is at the terminal count; drop en so no advance occurs.
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = '{sel: 4'b0100, an: 4'b1111, ft: 1'b0, nlat: 16'h9999};
            exp_q.push_back(e);
            step();
            got = exp_q.pop_front();
            obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL en0_terminal i=%0d got %h exp %h", i, obs, got);
            end
        end
        en = 1'b1;
        e = '{sel: 4'b1000, an: 4'b0111, ft: 1'b0, nlat: 16'h9999};
        exp_q.push_back(e);
        step();
        got = exp_q.pop_front();
        obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
        n_tests++;
        if (obs !== got) begin
            n_fail++;
            $display("FAIL en1_terminal_advance got %h exp %h", obs, got);
        end
    endtask

    task automatic test_async_reset();
        exp_t e, got, obs;
        do_reset(1'b1, 1'b0, 16'hABCD);
        repeat (25) step();
        n_tests++;
        if (sel0 !== 4'b0100 || nlat0 !== 16'hABCD) begin
            n_fail++;
            $display("FAIL async_pre got sel=%b nlat=%h exp sel=0100 nlat=abcd", sel0, nlat0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        e = '{sel: 4'b0001, an: 4'b1110, ft: 1'b0, nlat: 16'h0000};
        exp_q.push_back(e);
        got = exp_q.pop_front();
        obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
        n_tests++;
        if (obs !== got) begin
            n_fail++;
            $display("FAIL async_reset got %h exp %h", obs, got);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            e.sel  = (k == 4) ? 4'b0010 : 4'b0001;
            e.an   = ~e.sel;
            e.ft   = 1'b0;
            e.nlat = 16'h0000;
            exp_q.push_back(e);
            step();
            got = exp_q.pop_front();
            obs = '{sel: sel0, an: an0, ft: ft0, nlat: nlat0};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL async_release k=%0d got %h exp %h", k, obs, got);
            end
        end
    endtask

    task automatic test_prescale1();
        exp_t e, got, obs;
        do_reset(1'b1, 1'b0, 16'hBEEF);
        for (int k = 0; k <= 12; k++) begin
            e.sel  = onehot_of(k);
            e.an   = ~e.sel;
            e.ft   = (k > 0) && (k % 4 == 0);
            e.nlat = (k >= 4) ? 16'hBEEF : 16'h0000;
            exp_q.push_back(e);
            if (k > 0) step();
            got = exp_q.pop_front();
            obs = '{sel: sel1, an: an1, ft: ft1, nlat: nlat1};
            n_tests++;
            if (obs !== got) begin
                n_fail++;
                $display("FAIL prescale1 k=%0d got sel=%b ft=%b nlat=%h exp sel=%b ft=%b nlat=%h",
                         k, obs.sel, obs.ft, obs.nlat, got.sel, got.ft, got.nlat);
            end
        end
        n_tests++;
        if (oh_bad !== 0) begin
            n_fail++;
            $display("FAIL onehot_all got %0d bad cycles exp 0", oh_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_blanking();
        test_en_toggle();
        test_async_reset();
        test_prescale1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Refresh scheduler for the 4-digit multiplexed 7-segment display. It steps a one-hot digit select through digits 0..3 at a programmable rate. It latches the 16-bit counter value once per frame, so the hex-digit selector and decoder see a tear-free value. It also drives the active-low anodes, with optional leading-zero blanking. It sits between the 16-bit up/down counter and the selector / 7-segment decoder path.

## Interface
- PRESCALE, default 50000: clock cycles each digit is held; legal range 1..65535.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low. Single clock domain; reset is asynchronous and active-low.
- en  in  1  scan enable; 0 freezes the scan and blanks all anodes.
- blank_lz  in  1  leading-zero blanking request; sampled only at frame snapshot.
- N  in  16  live counter value (digit i = N[4i+3:4i]).
- n_lat  out  16  frame-latched value; feeds the selector N input.
- sel  out  4  one-hot digit select (0001 = digit 0 ... 1000 = digit 3); feeds the selector sel input.
- an  out  4  anodes, active-low; an[i] = 0 lights digit i.
- frame_tick  out  1  one-cycle pulse on the cycle after a new frame snapshot.

## Operation
- Registers:
  - cnt: prescaler, width ceil(log2(PRESCALE)), minimum 1 bit.
  - sel.
  - n_lat.
  - blank[3:0].
  - frame_tick.
- Reset values: cnt=0, sel=0001, n_lat=0, blank=0000, frame_tick=0.
- an is combinational from registers and en: an[i] = ~(en & sel[i] & ~blank[i]).
  - After reset: an=1110 if en=1, 1111 if en=0.
- Scan states are the four sel values. Transitions occur only on the terminal count, when en=1 and cnt==PRESCALE-1:
  - 0001 -> 0010 -> 0100 -> 1000 -> 0001 (wrap).
  - cnt returns to 0 on the same edge.
  - Otherwise, when en=1, cnt increments and sel holds.
- Frame snapshot happens at the terminal count while sel==1000 (the wrap to 0001). On that edge:
  - n_lat <= N.
  - blank <= bl(N, blank_lz).
  - frame_tick <= 1 for exactly one cycle.
- bl(N, b):
  - z3 = (N[15:12]==0)
  - z2 = z3 & (N[11:8]==0)
  - z1 = z2 & (N[7:4]==0)
  - blank = b ? {z3,z2,z1,1'b0} : 4'b0000.
  - Digit 0 is never blanked.
- en=0:
  - cnt and sel hold.
  - frame_tick=0.
  - n_lat <= N and blank <= bl(N, blank_lz) every cycle, so re-enable shows current data.
  - an=1111.
- Outside a snapshot (en=1), n_lat and blank hold regardless of N changes.
- sel is always exactly one-hot; no state ever produces 0000 or multi-hot.
- PRESCALE=1: sel advances every enabled cycle, and a full frame takes 4 cycles.

## Timing
- Digit dwell is PRESCALE cycles; frame period is 4*PRESCALE cycles.
- Snapshot edge to frame_tick high: same edge (registered), visible 1 cycle. n_lat/sel change on that same edge.
- en deassert: an goes to 1111 combinationally in the same cycle; scan resumes from the held sel/cnt on re-assert.
- en and terminal count together: en=1 advances as normal. en=0 on that cycle takes precedence, so there is no advance and no frame_tick.
- rst_n low at any time, mid-dwell or mid-frame: all registers go to reset values immediately, without waiting for clk. The first post-reset advance happens PRESCALE enabled cycles after rst_n release.
- Cycle counts on rst_n release: counting starts on the first rising edge with rst_n=1.

## Test plan
1. PRESCALE=4, en=1, N=16'hABCD, blank_lz=0, from reset:
   - sel=0001 for cycles 0-3, 0010 for 4-7, 0100 for 8-11, 1000 for 12-15, then 0001 at cycle 16.
   - frame_tick high only in cycle 16.
   - n_lat=0000 before cycle 16, ABCD from cycle 16.
   - an tracks ~sel.
2. Tear-free latch: after a snapshot of 1234, change N to 5678 mid-frame. n_lat stays 1234 until the next wrap, then becomes 5678.
3. Leading-zero blanking: blank_lz=1, N=16'h0030 snapshot. blank=1100, so an[3] and an[2] are never 0. Digits 1 and 0 light. N=0000 lights only digit 0. blank_lz=0 with N=0000 lights all digits.
4. en toggle: en=0 at cycle 6, with sel=0010 and cnt=2:
   - an=1111 in that cycle.
   - sel/cnt hold and no frame_tick.
   - n_lat follows N each cycle.
   - en=1 again: sel stays 0010 for 2 more cycles, then advances.
   - en=0 coincident with terminal count: no advance.
5. Async reset mid-scan at sel=0100, with rst_n pulsed low between clock edges: sel=0001, n_lat=0, an=1110 (en=1) immediately, before the next edge.
6. PRESCALE=1: sel rotates every cycle. frame_tick is high every 4th cycle, and sel is one-hot every cycle (assertion checked throughout all tests).
